// File: rtl/dirq_multi_issue_if.sv
// dirq_multi_issue_if: dispatch-in / issue-out bundle for the direct-result issue queue
`ifndef DIR_TYPE
`define DIR_TYPE 3'd4
`endif
`ifndef JIRL_TYPE
`define JIRL_TYPE 3'd5
`endif
interface dirq_multi_issue_if #(
    parameter int DEPTH = 16,
    parameter int DISP_W = 3,
    parameter int ISS_W = 2,
    parameter int ROB_W = 6,
    parameter int PREG_W = 6
);
    logic flush_dirq;
    logic stall_in;
    logic stall_issue;
    logic full_dirq;
    logic [$clog2(DEPTH):0] count_dirq;
    logic [DISP_W-1:0] ready_pc;
    logic [DISP_W-1:0][2:0] Type;
    logic [DISP_W-1:0][3:0] Conf;
    logic [DISP_W-1:0][31:0] imm;
    logic [DISP_W-1:0][31:0] pc;
    logic [DISP_W-1:0][PREG_W-1:0] Pd;
    logic [DISP_W-1:0] RegWr;
    logic [DISP_W-1:0][ROB_W-1:0] tag_rob;
    logic [ISS_W-1:0] ready_awake;
    logic [ISS_W-1:0][31:0] imm_awake;
    logic [ISS_W-1:0][PREG_W-1:0] Pd_awake;
    logic [ISS_W-1:0] RegWr_awake;
    logic [ISS_W-1:0][3:0] Conf_awake;
    logic [ISS_W-1:0][ROB_W-1:0] tag_rob_awake;
    logic [ISS_W-1:0] isJIRL_awake;
    modport master (
        output flush_dirq, stall_in, stall_issue, ready_pc, Type, Conf, imm, pc, Pd, RegWr, tag_rob,
        input full_dirq, count_dirq, ready_awake, imm_awake, Pd_awake, RegWr_awake, Conf_awake,
        tag_rob_awake, isJIRL_awake
    );
    modport slave (
        input flush_dirq, stall_in, stall_issue, ready_pc, Type, Conf, imm, pc, Pd, RegWr, tag_rob,
        output full_dirq, count_dirq, ready_awake, imm_awake, Pd_awake, RegWr_awake, Conf_awake,
        tag_rob_awake, isJIRL_awake
    );
endinterface

// File: rtl/dirq_multi_issue.sv
// dirq_multi_issue: in-order multi-issue queue for direct-result ops (imm loads, JIRL link writes)
module dirq_multi_issue #(
    parameter int DEPTH = 16,
    parameter int DISP_W = 3,
    parameter int ISS_W = 2,
    parameter int ROB_W = 6,
    parameter int PREG_W = 6
) (
    input logic clk,
    input logic rst,
    dirq_multi_issue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef struct packed {
        logic [31:0] val;
        logic [PREG_W-1:0] pd;
        logic wr;
        logic [3:0] conf;
        logic [ROB_W-1:0] tag;
        logic jirl;
    } ent_t;
    ent_t mem [DEPTH];
    ent_t slot [ISS_W];
    ent_t new_ent [DISP_W];
    logic [AW-1:0] waddr [DISP_W];
    logic [ISS_W-1:0] slot_v;
    logic [AW-1:0] ptr_young, ptr_old;
    logic [CW-1:0] count, enq_n, iss_n, add_n;
    logic [DISP_W-1:0] tok;
    logic enq;
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < DISP_W; i++) begin
            tok[i] = q.ready_pc[i] && (q.Type[i] == `DIR_TYPE || q.Type[i] == `JIRL_TYPE);
            waddr[i] = ptr_young + AW'(enq_n);
            new_ent[i] = '{val: q.Type[i] == `JIRL_TYPE ? q.pc[i] + 32'd4 : q.imm[i],
                           pd: q.Pd[i], wr: q.RegWr[i], conf: q.Conf[i], tag: q.tag_rob[i],
                           jirl: q.Type[i] == `JIRL_TYPE};
            enq_n = enq_n + CW'(tok[i]);
        end
    end
    // Conservative full: a same-cycle dequeue is not credited to dispatch.
    assign q.full_dirq = (CW'(DEPTH) - count) < CW'(DISP_W);
    assign q.count_dirq = count;
    assign enq = !q.full_dirq && !q.stall_in && !q.flush_dirq;
    assign add_n = enq ? enq_n : '0;
    assign iss_n = q.stall_issue ? '0 : (count < CW'(ISS_W) ? count : CW'(ISS_W));
    always_comb begin
        for (int k = 0; k < ISS_W; k++) begin
            q.ready_awake[k] = slot_v[k];
            q.imm_awake[k] = slot[k].val;
            q.Pd_awake[k] = slot[k].pd;
            q.RegWr_awake[k] = slot[k].wr;
            q.Conf_awake[k] = slot[k].conf;
            q.tag_rob_awake[k] = slot[k].tag;
            q.isJIRL_awake[k] = slot[k].jirl;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_young <= '0;
            ptr_old <= '0;
            count <= '0;
            slot_v <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            for (int k = 0; k < ISS_W; k++) slot[k] <= '0;
        end else if (q.flush_dirq) begin
            ptr_young <= '0;
            ptr_old <= '0;
            count <= '0;
            slot_v <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            for (int k = 0; k < ISS_W; k++) slot[k] <= '0;
        end else begin
            for (int i = 0; i < DISP_W; i++)
                if (enq && tok[i]) mem[waddr[i]] <= new_ent[i];
            for (int k = 0; k < ISS_W; k++) begin
                slot_v[k] <= CW'(k) < iss_n;
                slot[k] <= CW'(k) < iss_n ? mem[ptr_old + AW'(k)] : '0;
            end
            ptr_young <= ptr_young + AW'(add_n);
            ptr_old <= ptr_old + AW'(iss_n);
            count <= count + add_n - iss_n;
        end
    end
endmodule

// File: tb/tb_dirq_multi_issue.sv
// tb_dirq_multi_issue: directed checks of packing, issue order, backpressure, wrap, flush and reset
`ifndef DIR_TYPE
`define DIR_TYPE 3'd4
`endif
`ifndef JIRL_TYPE
`define JIRL_TYPE 3'd5
`endif
module tb_dirq_multi_issue;
    localparam int DEPTH = 16, DISP_W = 3, ISS_W = 2, ROB_W = 6, PREG_W = 6;
    logic clk, rst;
    int checks = 0, errors = 0;
    int exp_tag, got_n, nxt;
    dirq_multi_issue_if #(.DEPTH(DEPTH), .DISP_W(DISP_W), .ISS_W(ISS_W), .ROB_W(ROB_W), .PREG_W(PREG_W)) q ();
    dirq_multi_issue #(.DEPTH(DEPTH), .DISP_W(DISP_W), .ISS_W(ISS_W), .ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .rst(rst), .q(q)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_lanes();
        q.ready_pc = '0;
        q.Type = '0;
        q.Conf = '0;
        q.imm = '0;
        q.pc = '0;
        q.Pd = '0;
        q.RegWr = '0;
        q.tag_rob = '0;
    endtask
    task automatic put(input int i, input logic [2:0] t, input logic [31:0] im, input logic [31:0] p,
                       input logic [5:0] pd, input logic [5:0] tag);
        q.ready_pc[i] = 1'b1;
        q.Type[i] = t;
        q.imm[i] = im;
        q.pc[i] = p;
        q.Pd[i] = pd;
        q.RegWr[i] = 1'b1;
        q.Conf[i] = 4'h3;
        q.tag_rob[i] = tag;
    endtask
    task automatic bundle(input int base);
        idle_lanes();
        for (int i = 0; i < DISP_W; i++) put(i, `DIR_TYPE, 32'(base + i), 32'h0, 6'(i + 1), 6'(base + i));
    endtask
    task automatic scan();
        if (q.ready_awake[1]) chk("slot_order", q.ready_awake[0], 1);
        for (int k = 0; k < ISS_W; k++)
            if (q.ready_awake[k]) begin
                chk($sformatf("wrap_tag%0d", k), q.tag_rob_awake[k], exp_tag);
                exp_tag++;
                got_n++;
            end
    endtask
    initial begin
        rst = 1'b0;
        q.flush_dirq = 1'b0;
        q.stall_in = 1'b0;
        q.stall_issue = 1'b0;
        idle_lanes();
        repeat (2) tick();
        chk("rst_count", q.count_dirq, 0);
        chk("rst_ready", q.ready_awake, 0);
        chk("rst_full", q.full_dirq, 0);
        rst = 1'b1;
        tick();
        // single DIR op on lane 1
        put(1, `DIR_TYPE, 32'h1234, 32'h0, 6'd5, 6'd7);
        tick();
        chk("single_cnt1", q.count_dirq, 1);
        idle_lanes();
        tick();
        chk("single_ready", q.ready_awake, 2'b01);
        chk("single_imm", q.imm_awake[0], 32'h1234);
        chk("single_pd", q.Pd_awake[0], 5);
        chk("single_tag", q.tag_rob_awake[0], 7);
        chk("single_jirl", q.isJIRL_awake[0], 0);
        chk("single_wr", q.RegWr_awake[0], 1);
        chk("single_conf", q.Conf_awake[0], 3);
        chk("single_cnt0", q.count_dirq, 0);
        // JIRL link wraps past 2^32
        put(0, `JIRL_TYPE, 32'hdead, 32'hFFFF_FFFC, 6'd3, 6'd8);
        tick();
        idle_lanes();
        tick();
        chk("jirl_ready", q.ready_awake, 2'b01);
        chk("jirl_imm", q.imm_awake[0], 32'h0);
        chk("jirl_flag", q.isJIRL_awake[0], 1);
        // mixed bundle: lane0 wrong type, lane2 not valid
        put(0, 3'd0, 32'h1, 32'h0, 6'd1, 6'd9);
        put(1, `DIR_TYPE, 32'h2, 32'h0, 6'd2, 6'd10);
        put(2, `DIR_TYPE, 32'h3, 32'h0, 6'd3, 6'd11);
        q.ready_pc[2] = 1'b0;
        tick();
        chk("mixed_cnt", q.count_dirq, 1);
        idle_lanes();
        tick();
        chk("mixed_ready", q.ready_awake, 2'b01);
        chk("mixed_tag", q.tag_rob_awake[0], 10);
        // dispatch stall blocks enqueue
        q.stall_in = 1'b1;
        bundle(2);
        tick();
        chk("stall_in_cnt", q.count_dirq, 0);
        q.stall_in = 1'b0;
        idle_lanes();
        // fill under issue backpressure
        q.stall_issue = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bundle(16 + 3 * c);
            tick();
            chk("fill_ready", q.ready_awake, 0);
        end
        chk("fill_cnt", q.count_dirq, 15);
        chk("fill_full", q.full_dirq, 1);
        bundle(31);
        tick();
        chk("reject_cnt", q.count_dirq, 15);
        idle_lanes();
        q.stall_issue = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("drain_cnt", q.count_dirq, i < 8 ? 15 - 2 * i : 0);
            chk("drain_ready", q.ready_awake, i < 8 ? 2'b11 : 2'b01);
            chk("drain_tag0", q.tag_rob_awake[0], 16 + 2 * (i - 1));
            if (i < 8) chk("drain_tag1", q.tag_rob_awake[1], 17 + 2 * (i - 1));
            if (i == 1) chk("drain_full", q.full_dirq, 0);
        end
        // 40 ops through the pointer wrap with continuous issue
        exp_tag = 20;
        got_n = 0;
        nxt = 20;
        for (int c = 0; c < 20; c++) begin
            idle_lanes();
            put(c % 2, `DIR_TYPE, 32'(nxt), 32'h0, 6'd1, 6'(nxt));
            nxt++;
            put(2, `DIR_TYPE, 32'(nxt), 32'h0, 6'd2, 6'(nxt));
            nxt++;
            tick();
            scan();
        end
        idle_lanes();
        repeat (3) begin
            tick();
            scan();
        end
        chk("wrap_total", got_n, 40);
        chk("wrap_cnt", q.count_dirq, 0);
        // simultaneous enqueue/dequeue, then flush with enqueue
        q.stall_issue = 1'b1;
        bundle(40);
        tick();
        idle_lanes();
        put(0, `DIR_TYPE, 32'h0, 32'h0, 6'd1, 6'd43);
        tick();
        chk("sim_cnt4", q.count_dirq, 4);
        q.stall_issue = 1'b0;
        bundle(44);
        tick();
        chk("sim_cnt5", q.count_dirq, 5);
        chk("sim_ready", q.ready_awake, 2'b11);
        chk("sim_tag0", q.tag_rob_awake[0], 40);
        chk("sim_tag1", q.tag_rob_awake[1], 41);
        q.flush_dirq = 1'b1;
        bundle(50);
        tick();
        chk("flush_cnt", q.count_dirq, 0);
        chk("flush_ready", q.ready_awake, 0);
        chk("flush_tag", q.tag_rob_awake, 0);
        q.flush_dirq = 1'b0;
        idle_lanes();
        tick();
        chk("post_flush_cnt", q.count_dirq, 0);
        chk("post_flush_ready", q.ready_awake, 0);
        // asynchronous reset between edges
        q.stall_issue = 1'b1;
        bundle(1);
        tick();
        q.stall_issue = 1'b0;
        bundle(4);
        tick();
        chk("pre_rst_ready", q.ready_awake, 2'b11);
        chk("pre_rst_cnt", q.count_dirq, 4);
        idle_lanes();
        #2 rst = 1'b0;
        #1;
        chk("arst_cnt", q.count_dirq, 0);
        chk("arst_ready", q.ready_awake, 0);
        chk("arst_imm", q.imm_awake, 0);
        #2 rst = 1'b1;
        bundle(58);
        tick();
        idle_lanes();
        tick();
        chk("rst_first_ready", q.ready_awake, 2'b11);
        chk("rst_first_tag0", q.tag_rob_awake[0], 58);
        chk("rst_first_tag1", q.tag_rob_awake[1], 59);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
